// File: rtl/key_loader.sv
// key_loader
//  Collects an AES key as DATA_WIDTH-bit beats over a valid/ready stream,
//  shifting them in most-significant beat first until KEY_WIDTH bits are held.
//  It then hands the key to key_storage with a one-cycle key_write_o strobe
//  and wipes its own copy. With ONE_TIME set, the first successful write
//  raises a sticky lock that only rst_n can clear.
//
// Ports
//  clk            in   clock, rising edge
//  rst_n          in   asynchronous active-low reset
//  load_start_i   in   one-cycle pulse that opens a load session
//  abort_i        in   cancels an open session (honoured in LOAD only)
//  din_i          in   key beat, most-significant beat first
//  din_valid_i    in   din_i carries a beat
//  din_ready_o    out  loader accepts din_i this cycle (LOAD)
//  key_write_o    out  one-cycle write strobe to key_storage
//  key_data_in_o  out  assembled key; zero outside the write cycle
//  busy_o         out  session open (LOAD or WRITE)
//  done_o         out  one-cycle pulse after a completed write
//  error_o        out  one-cycle pulse after an abort or a rejected start
//  locked_o       out  sticky lock status (ONE_TIME builds only)
module key_loader #(
    parameter int KEY_WIDTH  = 128,
    parameter int DATA_WIDTH = 8,
    parameter bit ONE_TIME   = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  load_start_i,
    input  logic                  abort_i,
    input  logic [DATA_WIDTH-1:0] din_i,
    input  logic                  din_valid_i,
    output logic                  din_ready_o,
    output logic                  key_write_o,
    output logic [KEY_WIDTH-1:0]  key_data_in_o,
    output logic                  busy_o,
    output logic                  done_o,
    output logic                  error_o,
    output logic                  locked_o
);

    localparam int NBEATS = KEY_WIDTH / DATA_WIDTH;
    // One spare code so the count can reach NBEATS without wrapping.
    localparam int CNT_W  = $clog2(NBEATS + 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_WRITE = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    state_t                 state_q,     state_d;
    logic [KEY_WIDTH-1:0]   shreg_q,     shreg_d;
    logic [CNT_W-1:0]       cnt_q,       cnt_d;
    logic                   din_ready_q, din_ready_d;
    logic                   busy_q,      busy_d;
    logic                   key_write_q, key_write_d;
    logic [KEY_WIDTH-1:0]   key_data_q,  key_data_d;
    logic                   done_q,      done_d;
    logic                   error_q,     error_d;
    logic                   locked_q,    locked_d;

    logic                   beat_s;
    logic [KEY_WIDTH-1:0]   shreg_next_s;

    // A beat moves only when the registered ready is high, so din_ready_o
    // and the acceptance condition can never disagree.
    assign beat_s       = din_valid_i & din_ready_q;
    assign shreg_next_s = {shreg_q[KEY_WIDTH-DATA_WIDTH-1:0], din_i};

    // Next-state and next-output decode; every output is a registered copy.
    always_comb begin
        state_d     = state_q;
        shreg_d     = shreg_q;
        cnt_d       = cnt_q;
        din_ready_d = 1'b0;
        busy_d      = 1'b0;
        key_write_d = 1'b0;
        key_data_d  = {KEY_WIDTH{1'b0}};
        done_d      = 1'b0;
        error_d     = 1'b0;
        locked_d    = locked_q;

        case (state_q)
            ST_IDLE: begin
                if (load_start_i) begin
                    if (locked_q) begin
                        error_d = 1'b1;
                    end else begin
                        state_d     = ST_LOAD;
                        shreg_d     = {KEY_WIDTH{1'b0}};
                        cnt_d       = {CNT_W{1'b0}};
                        din_ready_d = 1'b1;
                        busy_d      = 1'b1;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end

            ST_LOAD: begin
                din_ready_d = 1'b1;
                busy_d      = 1'b1;
                // Abort wins over a beat presented in the same cycle.
                if (abort_i) begin
                    state_d     = ST_IDLE;
                    shreg_d     = {KEY_WIDTH{1'b0}};
                    cnt_d       = {CNT_W{1'b0}};
                    din_ready_d = 1'b0;
                    busy_d      = 1'b0;
                    error_d     = 1'b1;
                end else if (beat_s) begin
                    shreg_d = shreg_next_s;
                    cnt_d   = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
                    // Last beat: the write strobe goes out on the next cycle
                    // carrying the fully shifted key.
                    if (cnt_q == CNT_W'(NBEATS - 1)) begin
                        state_d     = ST_WRITE;
                        din_ready_d = 1'b0;
                        key_write_d = 1'b1;
                        key_data_d  = shreg_next_s;
                    end else begin
                        state_d = ST_LOAD;
                    end
                end else begin
                    state_d = ST_LOAD;
                end
            end

            ST_WRITE: begin
                state_d = ST_DONE;
                shreg_d = {KEY_WIDTH{1'b0}};
                cnt_d   = {CNT_W{1'b0}};
                done_d  = 1'b1;
                if (ONE_TIME) begin
                    locked_d = 1'b1;
                end else begin
                    locked_d = locked_q;
                end
            end

            ST_DONE: begin
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
                shreg_d = {KEY_WIDTH{1'b0}};
                cnt_d   = {CNT_W{1'b0}};
            end
        endcase
    end

    // State, key shift register and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            shreg_q     <= {KEY_WIDTH{1'b0}};
            cnt_q       <= {CNT_W{1'b0}};
            din_ready_q <= 1'b0;
            busy_q      <= 1'b0;
            key_write_q <= 1'b0;
            key_data_q  <= {KEY_WIDTH{1'b0}};
            done_q      <= 1'b0;
            error_q     <= 1'b0;
            locked_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            shreg_q     <= shreg_d;
            cnt_q       <= cnt_d;
            din_ready_q <= din_ready_d;
            busy_q      <= busy_d;
            key_write_q <= key_write_d;
            key_data_q  <= key_data_d;
            done_q      <= done_d;
            error_q     <= error_d;
            locked_q    <= locked_d;
        end
    end

    assign din_ready_o   = din_ready_q;
    assign key_write_o   = key_write_q;
    assign key_data_in_o = key_data_q;
    assign busy_o        = busy_q;
    assign done_o        = done_q;
    assign error_o       = error_q;
    assign locked_o      = locked_q;

endmodule

// File: tb/tb_key_loader.sv
// Directed bench for key_loader. Two instances share all stimulus: dut1 is
// built with ONE_TIME=1, dut0 with ONE_TIME=0. Inputs change 1ns after the
// rising edge and outputs are sampled there as well.
module tb_key_loader;

    logic         clk;
    logic         rst_n;
    logic         load_start;
    logic         abort;
    logic [7:0]   din;
    logic         din_valid;

    logic         din_ready_1, key_write_1, busy_1, done_1, error_1, locked_1;
    logic [127:0] key_data_1;
    logic         din_ready_0, key_write_0, busy_0, done_0, error_0, locked_0;
    logic [127:0] key_data_0;

    int nvec;
    int nerr;
    int wr1;
    int wr0;

    localparam logic [127:0] KEY_INC = 128'h000102030405060708090A0B0C0D0E0F;
    localparam logic [127:0] KEY_3X  = 128'h303132333435363738393A3B3C3D3E3F;
    localparam logic [127:0] KEY_FF  = {128{1'b1}};
    localparam logic [127:0] KEY_A5  = {16{8'hA5}};

    key_loader #(.KEY_WIDTH(128), .DATA_WIDTH(8), .ONE_TIME(1'b1)) dut1 (
        .clk(clk), .rst_n(rst_n), .load_start_i(load_start), .abort_i(abort),
        .din_i(din), .din_valid_i(din_valid), .din_ready_o(din_ready_1),
        .key_write_o(key_write_1), .key_data_in_o(key_data_1), .busy_o(busy_1),
        .done_o(done_1), .error_o(error_1), .locked_o(locked_1)
    );

    key_loader #(.KEY_WIDTH(128), .DATA_WIDTH(8), .ONE_TIME(1'b0)) dut0 (
        .clk(clk), .rst_n(rst_n), .load_start_i(load_start), .abort_i(abort),
        .din_i(din), .din_valid_i(din_valid), .din_ready_o(din_ready_0),
        .key_write_o(key_write_0), .key_data_in_o(key_data_0), .busy_o(busy_0),
        .done_o(done_0), .error_o(error_0), .locked_o(locked_0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Count write strobes seen by each instance (each strobe is one cycle).
    always @(posedge clk) begin
        if (key_write_1 === 1'b1) wr1 = wr1 + 1;
        if (key_write_0 === 1'b1) wr0 = wr0 + 1;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0; load_start = 1'b0; abort = 1'b0; din = 8'h00; din_valid = 1'b0;
        tick(); tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic start();
        load_start = 1'b1;
        tick();
        load_start = 1'b0;
    endtask

    // Present n beats back-to-back: first, first+step, ...
    task automatic feed(input logic [7:0] first, input logic [7:0] step, input int n);
        for (int i = 0; i < n; i++) begin
            din = first + 8'(i) * step;
            din_valid = 1'b1;
            tick();
        end
        din_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; load_start = 1'b0; abort = 1'b0; din = 8'h00; din_valid = 1'b0;
        tick();
        nvec++;
        if ({din_ready_1, key_write_1, busy_1, done_1, error_1, locked_1} !== 6'b000000) begin
            nerr++; $display("FAIL reset_flags got %b want 000000",
                {din_ready_1, key_write_1, busy_1, done_1, error_1, locked_1});
        end
        nvec++;
        if (key_data_1 !== 128'h0) begin
            nerr++; $display("FAIL reset_key got %h want 0", key_data_1);
        end
        nvec++;
        if ({din_ready_0, key_write_0, busy_0, done_0, error_0, locked_0} !== 6'b000000) begin
            nerr++; $display("FAIL reset_flags0 got %b want 000000",
                {din_ready_0, key_write_0, busy_0, done_0, error_0, locked_0});
        end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_basic();
        int w;
        do_reset();
        w = wr1;
        start();
        nvec++;
        if (din_ready_1 !== 1'b1 || busy_1 !== 1'b1) begin
            nerr++; $display("FAIL basic_open got ready=%b busy=%b want 1 1", din_ready_1, busy_1);
        end
        feed(8'h00, 8'h01, 16);
        nvec++;
        if (key_write_1 !== 1'b1 || key_data_1 !== KEY_INC) begin
            nerr++; $display("FAIL basic_write got kw=%b key=%h want 1 %h", key_write_1, key_data_1, KEY_INC);
        end
        nvec++;
        if (din_ready_1 !== 1'b0 || busy_1 !== 1'b1) begin
            nerr++; $display("FAIL basic_wr_flags got ready=%b busy=%b want 0 1", din_ready_1, busy_1);
        end
        tick();
        nvec++;
        if ({done_1, key_write_1, busy_1} !== 3'b100 || key_data_1 !== 128'h0) begin
            nerr++; $display("FAIL basic_done got done/kw/busy=%b key=%h want 100 0",
                {done_1, key_write_1, busy_1}, key_data_1);
        end
        tick();
        nvec++;
        if (locked_1 !== 1'b1 || done_1 !== 1'b0 || locked_0 !== 1'b0) begin
            nerr++; $display("FAIL basic_locked got locked1=%b done=%b locked0=%b want 1 0 0",
                locked_1, done_1, locked_0);
        end
        nvec++;
        if (wr1 - w !== 1) begin
            nerr++; $display("FAIL basic_wcount got %0d want 1", wr1 - w);
        end
    endtask

    task automatic test_gaps();
        int w;
        bit ready_ok;
        bit early_kw;
        do_reset();
        w = wr1;
        ready_ok = 1'b1;
        early_kw = 1'b0;
        start();
        for (int i = 0; i < 16; i++) begin
            din = 8'(i);
            din_valid = 1'b1;
            tick();
            if (i < 15) begin
                din_valid = 1'b0;
                din = 8'hEE;
                if (key_write_1 !== 1'b0) early_kw = 1'b1;
                tick();
                if (din_ready_1 !== 1'b1) ready_ok = 1'b0;
            end
        end
        din_valid = 1'b0;
        nvec++;
        if (ready_ok !== 1'b1 || early_kw !== 1'b0) begin
            nerr++; $display("FAIL gaps_ready got ready_ok=%b early_kw=%b want 1 0", ready_ok, early_kw);
        end
        nvec++;
        if (key_write_1 !== 1'b1 || key_data_1 !== KEY_INC) begin
            nerr++; $display("FAIL gaps_write got kw=%b key=%h want 1 %h", key_write_1, key_data_1, KEY_INC);
        end
        tick(); tick();
        nvec++;
        if (wr1 - w !== 1) begin
            nerr++; $display("FAIL gaps_wcount got %0d want 1", wr1 - w);
        end
    endtask

    task automatic test_abort();
        int w;
        do_reset();
        w = wr1;
        start();
        feed(8'h00, 8'h01, 6);
        din = 8'h06; din_valid = 1'b1; abort = 1'b1;
        tick();
        din_valid = 1'b0; abort = 1'b0;
        nvec++;
        if ({error_1, busy_1, din_ready_1, key_write_1} !== 4'b1000) begin
            nerr++; $display("FAIL abort_err got err/busy/ready/kw=%b want 1000",
                {error_1, busy_1, din_ready_1, key_write_1});
        end
        tick();
        nvec++;
        if (error_1 !== 1'b0 || key_write_1 !== 1'b0) begin
            nerr++; $display("FAIL abort_pulse got err=%b kw=%b want 0 0", error_1, key_write_1);
        end
        start();
        feed(8'hFF, 8'h00, 16);
        nvec++;
        if (key_write_1 !== 1'b1 || key_data_1 !== KEY_FF) begin
            nerr++; $display("FAIL abort_reload got kw=%b key=%h want 1 %h", key_write_1, key_data_1, KEY_FF);
        end
        tick(); tick();
        nvec++;
        if (wr1 - w !== 1) begin
            nerr++; $display("FAIL abort_wcount got %0d want 1", wr1 - w);
        end
    endtask

    task automatic test_lock();
        int w1;
        int w0;
        bit ready1_low;
        do_reset();
        start();
        feed(8'h00, 8'h01, 16);
        tick(); tick();
        w1 = wr1;
        w0 = wr0;
        start();
        nvec++;
        if ({error_1, din_ready_1, busy_1} !== 3'b100) begin
            nerr++; $display("FAIL lock_reject got err/ready/busy=%b want 100",
                {error_1, din_ready_1, busy_1});
        end
        nvec++;
        if ({error_0, din_ready_0, busy_0} !== 3'b011) begin
            nerr++; $display("FAIL lock_reload0 got err/ready/busy=%b want 011",
                {error_0, din_ready_0, busy_0});
        end
        ready1_low = 1'b1;
        for (int i = 0; i < 16; i++) begin
            din = 8'h30 + 8'(i);
            din_valid = 1'b1;
            tick();
            if (din_ready_1 !== 1'b0) ready1_low = 1'b0;
        end
        din_valid = 1'b0;
        nvec++;
        if (key_write_0 !== 1'b1 || key_data_0 !== KEY_3X || key_write_1 !== 1'b0) begin
            nerr++; $display("FAIL lock_second got kw0=%b key0=%h kw1=%b want 1 %h 0",
                key_write_0, key_data_0, key_write_1, KEY_3X);
        end
        tick(); tick();
        nvec++;
        if (wr1 - w1 !== 0 || wr0 - w0 !== 1 || ready1_low !== 1'b1 || locked_1 !== 1'b1) begin
            nerr++; $display("FAIL lock_counts got wr1=%0d wr0=%0d ready1_low=%b locked=%b want 0 1 1 1",
                wr1 - w1, wr0 - w0, ready1_low, locked_1);
        end
    endtask

    task automatic test_reset_mid();
        int w;
        do_reset();
        w = wr1;
        start();
        feed(8'h11, 8'h01, 10);
        rst_n = 1'b0;
        tick();
        nvec++;
        if ({key_write_1, busy_1, din_ready_1} !== 3'b000 || key_data_1 !== 128'h0) begin
            nerr++; $display("FAIL rstmid_drop got kw/busy/ready=%b key=%h want 000 0",
                {key_write_1, busy_1, din_ready_1}, key_data_1);
        end
        rst_n = 1'b1;
        tick();
        start();
        feed(8'hA5, 8'h00, 16);
        nvec++;
        if (key_write_1 !== 1'b1 || key_data_1 !== KEY_A5) begin
            nerr++; $display("FAIL rstmid_key got kw=%b key=%h want 1 %h", key_write_1, key_data_1, KEY_A5);
        end
        tick(); tick();
        nvec++;
        if (wr1 - w !== 1) begin
            nerr++; $display("FAIL rstmid_wcount got %0d want 1", wr1 - w);
        end
    endtask

    task automatic test_start_in_load();
        int w;
        do_reset();
        w = wr1;
        start();
        feed(8'h00, 8'h01, 3);
        din = 8'h03; din_valid = 1'b1; load_start = 1'b1;
        tick();
        load_start = 1'b0;
        nvec++;
        if (error_1 !== 1'b0 || din_ready_1 !== 1'b1) begin
            nerr++; $display("FAIL sil_ignore got err=%b ready=%b want 0 1", error_1, din_ready_1);
        end
        feed(8'h04, 8'h01, 12);
        nvec++;
        if (key_write_1 !== 1'b1 || key_data_1 !== KEY_INC) begin
            nerr++; $display("FAIL sil_key got kw=%b key=%h want 1 %h", key_write_1, key_data_1, KEY_INC);
        end
        tick(); tick();
        nvec++;
        if (wr1 - w !== 1) begin
            nerr++; $display("FAIL sil_wcount got %0d want 1", wr1 - w);
        end
    endtask

    initial begin
        nvec = 0;
        nerr = 0;
        wr1 = 0;
        wr0 = 0;
        rst_n = 1'b0; load_start = 1'b0; abort = 1'b0; din = 8'h00; din_valid = 1'b0;
        test_reset();
        test_basic();
        test_gaps();
        test_abort();
        test_lock();
        test_reset_mid();
        test_start_in_load();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
